fetch_unit: RTL and testbench

//  Instruction fetch stage ahead of the dual-port instruction memory. Each cycle it can

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a dual-port instruction memory.
// Each request reads the word holding PC on port A and the following word on port B.
// The 128-bit concatenation is aligned to the requested 16-bit slot, giving a
// 4-instruction bundle in one access. Bundles pass through an output register and a
// one-entry skid buffer so that decode back-pressure never drops an in-flight read.
module fetch_unit #(
  parameter int                ADDR_W   = 14,
  parameter int                DATA_W   = 64,
  parameter int                INST_W   = 16,
  parameter logic [ADDR_W+1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr_a,
  output logic [ADDR_W-1:0] imem_addr_b,
  input  logic [DATA_W-1:0] imem_data_a,
  input  logic [DATA_W-1:0] imem_data_b,
  input  logic              redirect,
  input  logic [ADDR_W+1:0] redirect_pc,
  input  logic              fetch_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W+1:0] inst_pc
);

  localparam int PC_W  = ADDR_W + 2;
  localparam int SLOTS = 4;

  // Fetch pointer and in-flight request tracking
  logic [PC_W-1:0]   pc_req_reg,     pc_req_next;
  logic              inflight_v_reg, inflight_v_next;
  logic [PC_W-1:0]   pc_q_reg,       pc_q_next;

  // Output register
  logic              out_v_reg,      out_v_next;
  logic [DATA_W-1:0] out_data_reg,   out_data_next;
  logic [PC_W-1:0]   out_pc_reg,     out_pc_next;

  // One-entry skid buffer
  logic              skid_v_reg,     skid_v_next;
  logic [DATA_W-1:0] skid_data_reg,  skid_data_next;
  logic [PC_W-1:0]   skid_pc_reg,    skid_pc_next;

  logic              transfer;
  logic              issue;

  // Alignment: the bundle for slot offset s starts s instructions into word A.
  logic [2*DATA_W-1:0] cat;
  logic [DATA_W-1:0]   cand [SLOTS];
  logic [DATA_W-1:0]   aligned;

  assign cat = {imem_data_a, imem_data_b};

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_align
      assign cand[gi] = cat[2*DATA_W-1-INST_W*gi -: DATA_W];
    end
  endgenerate

  assign aligned = cand[pc_q_reg[1:0]];

  // Both ports are always addressed from the current fetch pointer.
  assign imem_addr_a = pc_req_reg[PC_W-1:2];
  assign imem_addr_b = pc_req_reg[PC_W-1:2] + ADDR_W'(1);

  assign inst_valid = out_v_reg;
  assign inst_out   = out_data_reg;
  assign inst_pc    = out_pc_reg;

  assign transfer = out_v_reg && fetch_ready;
  // A new request is only issued when its data is guaranteed a free slot next cycle.
  assign issue    = !skid_v_reg && !(inflight_v_reg && out_v_reg && !fetch_ready);

  // Next-state: issue, arrival routing, skid drain, with redirect overriding all of it
  always_comb begin
    pc_req_next     = pc_req_reg;
    inflight_v_next = 1'b0;
    pc_q_next       = pc_q_reg;
    out_v_next      = out_v_reg;
    out_data_next   = out_data_reg;
    out_pc_next     = out_pc_reg;
    skid_v_next     = skid_v_reg;
    skid_data_next  = skid_data_reg;
    skid_pc_next    = skid_pc_reg;

    if (issue) begin
      inflight_v_next = 1'b1;
      pc_q_next       = pc_req_reg;
      pc_req_next     = pc_req_reg + PC_W'(4);
    end

    if (transfer || !out_v_reg) begin
      // Output slot is free this cycle; oldest buffered bundle goes first.
      if (skid_v_reg) begin
        out_v_next     = 1'b1;
        out_data_next  = skid_data_reg;
        out_pc_next    = skid_pc_reg;
        skid_v_next    = inflight_v_reg;
        skid_data_next = aligned;
        skid_pc_next   = pc_q_reg;
      end else if (inflight_v_reg) begin
        out_v_next    = 1'b1;
        out_data_next = aligned;
        out_pc_next   = pc_q_reg;
      end else begin
        out_v_next = 1'b0;
      end
    end else if (inflight_v_reg) begin
      // Output is held by decode: park the arriving bundle.
      skid_v_next    = 1'b1;
      skid_data_next = aligned;
      skid_pc_next   = pc_q_reg;
    end

    if (redirect) begin
      inflight_v_next = 1'b0;
      out_v_next      = 1'b0;
      skid_v_next     = 1'b0;
      pc_req_next     = redirect_pc;
    end
  end

  // State registers with synchronous reset back to the reset PC and empty buffers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_req_reg     <= RESET_PC;
      inflight_v_reg <= 1'b0;
      pc_q_reg       <= '0;
      out_v_reg      <= 1'b0;
      out_data_reg   <= '0;
      out_pc_reg     <= '0;
      skid_v_reg     <= 1'b0;
      skid_data_reg  <= '0;
      skid_pc_reg    <= '0;
    end else begin
      pc_req_reg     <= pc_req_next;
      inflight_v_reg <= inflight_v_next;
      pc_q_reg       <= pc_q_next;
      out_v_reg      <= out_v_next;
      out_data_reg   <= out_data_next;
      out_pc_reg     <= out_pc_next;
      skid_v_reg     <= skid_v_next;
      skid_data_reg  <= skid_data_next;
      skid_pc_reg    <= skid_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven directed vectors, hand-written stall/flush sequences and
// randomized traffic against a reference model. Memory word w holds instructions
// 4w+1..4w+4, so the bundle at any PC p is simply {p+1, p+2, p+3, p+4} (mod 2^16).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        fetch_ready = 1'b1;
  logic [13:0] imem_addr_a, imem_addr_b;
  logic [63:0] imem_data_a, imem_data_b;
  logic        inst_valid;
  logic [63:0] inst_out;
  logic [15:0] inst_pc;

  logic [63:0] mem [0:16383];

  always #5 clk = ~clk;

  // Synchronous-read dual-port memory model
  always @(posedge clk) begin
    imem_data_a <= mem[imem_addr_a];
    imem_data_b <= mem[imem_addr_b];
  end

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr_a (imem_addr_a),
    .imem_addr_b (imem_addr_b),
    .imem_data_a (imem_data_a),
    .imem_data_b (imem_data_b),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_pc = 16'h0;
  int          m_since = 100;
  int          idle = 0;
  logic        p_valid = 1'b0;
  logic [63:0] p_out = 64'h0;
  logic [15:0] p_pc = 16'h0;

  function automatic logic [63:0] bundle(input logic [15:0] p);
    logic [15:0] i0, i1, i2, i3;
    i0 = p + 16'd1;
    i1 = p + 16'd2;
    i2 = p + 16'd3;
    i3 = p + 16'd4;
    return {i0, i1, i2, i3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then check against the model.
  task automatic cyc(input logic r, input logic rd, input logic [15:0] rp, input logic rdy);
    logic [13:0] nb;
    rst = r;
    redirect = rd;
    redirect_pc = rp;
    fetch_ready = rdy;
    @(posedge clk);
    #1;
    if (r) begin
      m_pc = 16'h0000;
      m_since = 0;
      idle = 0;
      chk("rst_valid", inst_valid, 0);
      chk("rst_out", inst_out, 0);
      chk("rst_pc", inst_pc, 0);
    end else if (rd) begin
      m_pc = rp;
      m_since = 0;
      idle = 0;
      chk("redir_valid", inst_valid, 0);
    end else begin
      if (p_valid && rdy) m_pc = m_pc + 16'd4;
      if (m_since < 100) m_since++;
      if (m_since == 1) chk("lat_bubble", inst_valid, 0);
      if (m_since == 2) chk("lat_first", inst_valid, 1);
      if (p_valid && !rdy) begin
        chk("hold_valid", inst_valid, 1);
        chk("hold_out", inst_out, p_out);
        chk("hold_pc", inst_pc, p_pc);
      end
      if (inst_valid) begin
        chk("seq_pc", inst_pc, m_pc);
        chk("seq_data", inst_out, bundle(m_pc));
      end
      idle = inst_valid ? 0 : idle + 1;
      if (idle > 6) begin
        chk("starve", 64'(idle), 64'd6);
        idle = 0;
      end
    end
    nb = imem_addr_a + 14'd1;
    chk("addr_b", imem_addr_b, nb);
    p_valid = inst_valid;
    p_out = inst_out;
    p_pc = inst_pc;
  endtask

  typedef struct {
    logic        r;
    logic        rd;
    logic [15:0] rp;
    logic        rdy;
    logic        ev;
    logic [15:0] epc;
    logic [13:0] ea;
  } vec_t;

  vec_t tbl [16];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [13:0] frozen_a;
    for (int w = 0; w < 16384; w++)
      mem[w] = {16'(4*w+1), 16'(4*w+2), 16'(4*w+3), 16'(4*w+4)};

    //        r     rd    rp        rdy   ev    epc       addr_a
    tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0001};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 14'h0002};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004, 14'h0003};
    tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0008, 14'h0004};
    tbl[5]  = '{1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 16'h0000, 14'h0001};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0002};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0006, 14'h0003};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h000A, 14'h0004};
    tbl[9]  = '{1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0000, 14'h3FFF};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0000};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 14'h0001};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 14'h0002};
    tbl[13] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0000};
    tbl[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 14'h0001};
    tbl[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 14'h0002};

    // Directed vectors
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].rd, tbl[i].rp, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), inst_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_addr_a", i), imem_addr_a, tbl[i].ea);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].epc);
        chk($sformatf("tbl%0d_data", i), inst_out, bundle(tbl[i].epc));
      end
      if (i == 2)  chk("lit_mem0", inst_out, 64'h0001_0002_0003_0004);
      if (i == 7)  chk("lit_pc6", inst_out, 64'h0007_0008_0009_000A);
      if (i == 11) chk("lit_wrap", inst_out, 64'hFFFF_0000_0001_0002);
      $display("vec %0d: valid=%0b pc=%h out=%h addr_a=%h", i, inst_valid, inst_pc, inst_out, imem_addr_a);
    end

    // Back-pressure for 5 cycles mid-stream: addresses frozen, output held.
    cyc(1'b1, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 16'h0, 1'b1);
    frozen_a = imem_addr_a;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      chk("stall_addr", imem_addr_a, frozen_a);
      $display("stall %0d: valid=%0b pc=%h addr_a=%h", i, inst_valid, inst_pc, imem_addr_a);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b1);
      $display("release %0d: valid=%0b pc=%h", i, inst_valid, inst_pc);
    end

    // Redirect while both buffers are full: both bundles dropped.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 1'b1, 16'h1232, 1'b0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    chk("flush_bubble", inst_valid, 0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0);
    chk("flush_valid", inst_valid, 1);
    chk("flush_pc", inst_pc, 16'h1232);
    chk("flush_data", inst_out, bundle(16'h1232));
    $display("flush: valid=%0b pc=%h out=%h", inst_valid, inst_pc, inst_out);

    // Randomized traffic checked by the model inside cyc()
    for (int i = 0; i < 1500; i++) begin
      logic r, rd, rdy;
      logic [15:0] rp;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 24) == 0);
      rp  = 16'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, rd, rp, rdy);
      $display("rnd %0d: rst=%0b redir=%0b rdy=%0b valid=%0b pc=%h", i, r, rd, rdy, inst_valid, inst_pc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
